// File: rtl/vga_fb_fetch_ctrl_pkg.sv
// vga_fb_fetch_ctrl_pkg: shared FSM encoding and resolution-derived constants for the framebuffer fetch path.
package vga_fb_fetch_ctrl_pkg;
  typedef enum logic [1:0] {WAIT_VS, FLUSH, ACTIVE, DONE} state_e;
  localparam int HVA_DEF = 640;
  localparam int VVA_DEF = 480;
  function automatic int frame_pix(input int h, input int v);
    return h * v;
  endfunction
endpackage

// File: rtl/vga_fb_fetch_ctrl_fifo.sv
// vga_pix_fifo: synchronous prefetch FIFO with occupancy output and a flush that wins over push.
module vga_pix_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk_vga,
  input  logic                       rst_vga_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DW-1:0]              wdata_i,
  output logic [DW-1:0]              rdata_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] level_q;
  always_ff @(posedge clk_vga)
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  always_ff @(posedge clk_vga or negedge rst_vga_n)
    if (!rst_vga_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= push_i ? wr_q + 1'b1 : wr_q;
      rd_q    <= pop_i ? rd_q + 1'b1 : rd_q;
      level_q <= level_q + CW'(push_i) - CW'(pop_i);
    end
  assign rdata_o = mem_q[rd_q];
  assign level_o = level_q;
endmodule

// File: rtl/vga_fb_fetch_ctrl.sv
// vga_fb_fetch_ctrl: raster-order pixel prefetch into a local FIFO, sharing one SRAM port with host writes.
module vga_fb_fetch_ctrl
  import vga_fb_fetch_ctrl_pkg::*;
#(
  parameter int             HVA     = HVA_DEF,
  parameter int             VVA     = VVA_DEF,
  parameter int             AW      = 19,
  parameter int             DW      = 16,
  parameter int             DEPTH   = 16,
  parameter int             HIWM    = 12,
  parameter logic [AW-1:0]  FB_BASE = '0
) (
  input  logic          clk_vga,
  input  logic          rst_vga_n,
  input  logic          vga_vsync,
  input  logic          vga_video_on,
  input  logic          first_pixel,
  output logic [DW-1:0] pix_data,
  output logic          underrun,
  input  logic          host_req,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);
  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam int            LW        = CW + 1;
  localparam int            FRAME_PIX = frame_pix(HVA, VVA);
  localparam logic [AW-1:0] LAST      = FB_BASE + AW'(FRAME_PIX - 1);
  state_e        state_q;
  logic          vs_q, run_q, lock_q, lock_we_q, underrun_q;
  logic [CW-1:0] out_q, out_d, drop_q, level;
  logic [AW-1:0] fetch_addr_q;
  logic [DW-1:0] pix_q, fifo_rdata;
  logic [LW-1:0] lo;
  logic          vs_fall, elig, sel_fetch, sel_host, rd_acc, push, pop, flush;
  assign vs_fall   = vs_q & ~vga_vsync;
  assign lo        = LW'(level) + LW'(out_q);
  assign elig      = state_q == ACTIVE && lo < LW'(DEPTH);
  // An ungranted request keeps its owner so mem_* never switch mid-handshake.
  assign sel_fetch = elig && (lock_q ? !lock_we_q : (lo < LW'(HIWM) || !host_req));
  assign sel_host  = run_q && !sel_fetch && host_req;
  assign mem_req   = sel_fetch | sel_host;
  assign mem_we    = sel_host;
  assign mem_addr  = sel_fetch ? fetch_addr_q : sel_host ? host_addr : '0;
  assign mem_wdata = sel_host ? host_wdata : '0;
  assign host_gnt  = mem_gnt & mem_req & mem_we;
  assign rd_acc    = mem_gnt & sel_fetch;
  assign push      = mem_rvalid && drop_q == '0;
  assign pop       = vga_video_on && level != '0;
  assign flush     = vs_fall || state_q == FLUSH;
  assign out_d     = out_q + CW'(rd_acc) - CW'(mem_rvalid);
  vga_pix_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk_vga   (clk_vga),
    .rst_vga_n (rst_vga_n),
    .flush_i   (flush),
    .push_i    (push),
    .pop_i     (pop),
    .wdata_i   (mem_rdata),
    .rdata_o   (fifo_rdata),
    .level_o   (level)
  );
  always_ff @(posedge clk_vga or negedge rst_vga_n)
    if (!rst_vga_n) begin
      state_q      <= WAIT_VS;
      vs_q         <= 1'b0;
      run_q        <= 1'b0;
      lock_q       <= 1'b0;
      lock_we_q    <= 1'b0;
      out_q        <= '0;
      drop_q       <= '0;
      fetch_addr_q <= '0;
      pix_q        <= '0;
      underrun_q   <= 1'b0;
    end else begin
      vs_q         <= vga_vsync;
      run_q        <= 1'b1;
      lock_q       <= mem_req & ~mem_gnt;
      lock_we_q    <= mem_we;
      out_q        <= out_d;
      // Every read still in flight after the vsync cycle belongs to the old frame.
      drop_q       <= vs_fall ? out_d : (mem_rvalid && drop_q != '0) ? drop_q - 1'b1 : drop_q;
      fetch_addr_q <= vs_fall ? FB_BASE : rd_acc ? fetch_addr_q + 1'b1 : fetch_addr_q;
      state_q      <= vs_fall ? FLUSH :
                      (state_q == FLUSH && drop_q == '0) ? ACTIVE :
                      (state_q == ACTIVE && rd_acc && fetch_addr_q == LAST) ? DONE : state_q;
      pix_q        <= pop ? fifo_rdata : vga_video_on ? '0 : pix_q;
      underrun_q   <= underrun_q | (level == '0 && (vga_video_on || first_pixel));
    end
  assign pix_data = pix_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_vga_fb_fetch_ctrl.sv
// tb_vga_fb_fetch_ctrl: randomized frames against a queue-based reference of the fetch/arbitration rules.
module tb_vga_fb_fetch_ctrl;
  localparam int HVA = 8, VVA = 8, AW = 19, DW = 16, DEPTH = 16, HIWM = 12;
  localparam int FRAME = HVA * VVA;
  localparam int BASE = 100;
  logic          clk_vga = 1'b0, rst_vga_n = 1'b0;
  logic          vga_vsync = 1'b1, vga_video_on = 1'b0, first_pixel = 1'b0;
  logic          host_req = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0, mem_rdata = '0;
  logic [DW-1:0] pix_data, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          underrun, host_gnt, mem_req, mem_we;
  always #5 clk_vga = ~clk_vga;
  vga_fb_fetch_ctrl #(.HVA(HVA), .VVA(VVA), .AW(AW), .DW(DW), .DEPTH(DEPTH), .HIWM(HIWM),
                      .FB_BASE(AW'(BASE))) dut (
    .clk_vga(clk_vga), .rst_vga_n(rst_vga_n), .vga_vsync(vga_vsync), .vga_video_on(vga_video_on),
    .first_pixel(first_pixel), .pix_data(pix_data), .underrun(underrun), .host_req(host_req),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  typedef struct {int due; int data; int ep;} rd_t;
  typedef struct {int due; int pix; bit und;} px_t;
  typedef struct {int addr; int data;} hw_t;
  rd_t pend[$];
  px_t exp_pix[$];
  hw_t host_q[$];
  int  q_fifo[$];
  int  addr_q[$];
  int  cyc, epoch, reads_ep, flush_clear, last_due, stall_left, n_chk, n_fail;
  bit  und_m, prev_stall, vs_prev, host_busy, host_en, force_host, rand_gnt, rebuild;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic model();
    int  lo, d, pix;
    bit  act, emp;
    rd_t e;
    if (rebuild) begin
      addr_q.delete();
      for (int i = 0; i < FRAME; i++) addr_q.push_back(BASE + i);
      rebuild = 0;
    end
    lo = q_fifo.size();
    foreach (pend[i]) if (pend[i].ep == epoch) lo++;
    act = epoch > 0 && reads_ep < FRAME && cyc >= flush_clear + 2 && !prev_stall;
    if (act && lo < HIWM) chk("fetch_prio", 32'(mem_req && !mem_we), 1);
    else if (act && lo < DEPTH && host_req) chk("host_share", 32'(mem_req && mem_we), 1);
    else if (act && lo >= DEPTH) chk("credit", 32'(mem_req && !mem_we), 0);
    if (epoch > 0 && reads_ep == FRAME && host_req && mem_gnt) chk("done_b2b", 32'(host_gnt), 1);
    emp = q_fifo.size() == 0;
    if (emp && (vga_video_on || first_pixel)) und_m = 1;
    if (vga_video_on) begin
      pix = emp ? 0 : q_fifo.pop_front();
      exp_pix.push_back(px_t'{cyc + 1, pix, und_m});
    end
    if (mem_rvalid) begin
      e = pend.pop_front();
      if (e.ep == epoch) q_fifo.push_back(e.data);
      else flush_clear = cyc;
    end
    if (mem_req && !mem_we && mem_gnt) begin
      d = cyc + int'($urandom_range(1, 3));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back(rd_t'{d, int'(mem_addr) & 'hFFFF, epoch});
      reads_ep++;
    end
    if (host_gnt) host_busy = 0;
    if (vs_prev && !vga_vsync) begin
      epoch++;
      q_fifo.delete();
      reads_ep = 0;
      flush_clear = cyc;
      rebuild = 1;
    end
    vs_prev = vga_vsync;
    prev_stall = mem_req && !mem_gnt;
  endtask
  task automatic step(input bit vs, input bit vid, input bit fp);
    @(posedge clk_vga);
    cyc++;
    #1;
    vga_vsync = vs;
    vga_video_on = vid;
    first_pixel = fp;
    mem_gnt = stall_left > 0 ? 1'b0 : rand_gnt ? ($urandom_range(0, 7) != 0) : 1'b1;
    if (stall_left > 0) stall_left--;
    if (host_en && !host_busy && (force_host || $urandom_range(0, 3) == 0)) begin
      host_busy = 1;
      host_addr = AW'($urandom);
      host_wdata = DW'($urandom);
      host_q.push_back(hw_t'{int'(host_addr), int'(host_wdata)});
    end
    host_req = host_busy;
    mem_rvalid = pend.size() > 0 && pend[0].due == cyc;
    mem_rdata = mem_rvalid ? DW'(pend[0].data) : '0;
    @(negedge clk_vga);
    model();
  endtask
  task automatic check_outputs_zero(input string tag);
    chk({tag, "_pix"}, 32'(pix_data), 0);
    chk({tag, "_underrun"}, 32'(underrun), 0);
    chk({tag, "_host_gnt"}, 32'(host_gnt), 0);
    chk({tag, "_mem_req"}, 32'(mem_req), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
  endtask
  task automatic do_reset();
    #1;
    rst_vga_n = 0;
    vga_vsync = 1; vga_video_on = 0; first_pixel = 0;
    host_req = 0; host_busy = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    pend.delete(); exp_pix.delete(); host_q.delete(); q_fifo.delete(); addr_q.delete();
    epoch = 0; reads_ep = 0; und_m = 0; prev_stall = 0; vs_prev = 1; rebuild = 0; stall_left = 0;
    #1;
    check_outputs_zero("in_reset");
    repeat (5) begin @(posedge clk_vga); cyc++; end
    last_due = cyc;
    #1 rst_vga_n = 1;
    @(negedge clk_vga);
    check_outputs_zero("post_reset");
  endtask
  task automatic run_frame(input int lines, input bit trunc, input int stall_line, input int stall_len);
    step(0, 0, 0);
    step(0, 0, 0);
    repeat (40) step(1, 0, 0);
    for (int l = 0; l < lines; l++) begin
      if (l == stall_line) stall_left = stall_len;
      for (int p = 0; p < HVA; p++) step(1, 1, l == 0 && p == 0);
      if (!(trunc && l == lines - 1)) repeat (24) step(1, 0, 0);
    end
  endtask
  always @(negedge clk_vga) begin
    #1;
    if (rst_vga_n) begin
      if (mem_req && !mem_we && mem_gnt) begin
        if (addr_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_read: got read of addr %0d, expected no read (cycle %0d)", mem_addr, cyc);
        end else chk("read_addr", 32'(mem_addr), addr_q.pop_front());
      end
      if (host_gnt) begin
        if (host_q.size() == 0) chk("host_gnt_spurious", 32'(host_gnt), 0);
        else begin
          hw_t h;
          h = host_q.pop_front();
          chk("host_addr", 32'(mem_addr), h.addr);
          chk("host_wdata", 32'(mem_wdata), h.data);
        end
      end
      while (exp_pix.size() > 0 && exp_pix[0].due <= cyc) begin
        px_t x;
        x = exp_pix.pop_front();
        chk("pix_data", 32'(pix_data), x.pix);
        chk("underrun", 32'(underrun), 32'(x.und));
      end
    end
  end
  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    host_en = 0; force_host = 0; rand_gnt = 0;
    do_reset();
    repeat (5) begin
      step(1, 0, 0);
      chk("idle_no_req", 32'(mem_req), 0);
    end
    host_en = 1;
    run_frame(VVA, 0, -1, 0);
    chk("frame1_all_reads", addr_q.size(), 0);
    force_host = 1;
    repeat (10) step(1, 0, 0);
    force_host = 0;
    rand_gnt = 1;
    run_frame(2, 1, -1, 0);
    run_frame(VVA, 0, -1, 0);
    chk("frame3_all_reads", addr_q.size(), 0);
    rand_gnt = 0;
    run_frame(VVA, 0, 2, 80);
    chk("underrun_sticky", 32'(underrun), 1);
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_fb_fetch_ctrl.md
# vga_fb_fetch_ctrl

Framebuffer fetch controller and memory arbiter sitting between the shared pixel SRAM and the vga_sync timing generator. It prefetches pixels in raster order into a local FIFO so one pixel is available every `clk_vga` cycle while `vga_video_on` is high. It also shares the single SRAM port with a host write requester. Display fetch has priority whenever the FIFO is not comfortably full; host writes otherwise use the remaining slots.

## Interface

Parameters:
- `HVA`, 640, visible pixels per line
- `VVA`, 480, visible lines per frame
- `AW`, 19, SRAM word address width
- `DW`, 16, pixel/SRAM data width
- `DEPTH`, 16, prefetch FIFO depth (power of 2)
- `HIWM`, 12, fetch has priority while `level + outstanding < HIWM`
- `FB_BASE`, 0, SRAM address of pixel (0,0)

Ports:
- `clk_vga` in 1: pixel clock, the only clock.
- `rst_vga_n` in 1: asynchronous, active-low reset.
- `vga_vsync` in 1: from vga_sync, active-low sync pulse.
- `vga_video_on` in 1: from vga_sync; pop one pixel per cycle while high.
- `first_pixel` in 1: from vga_sync; high in the cycle of pixel (0,0).
- `pix_data` out DW: registered pixel; valid in the cycle after a pop.
- `underrun` out 1: sticky; set on a pop while the FIFO is empty.
- `host_req` in 1: host write request; held until granted.
- `host_addr` in AW: host write address.
- `host_wdata` in DW: host write data.
- `host_gnt` out 1: write accepted this cycle.
- `mem_req` out 1: SRAM request.
- `mem_we` out 1: 1 = write (host), 0 = read (fetch).
- `mem_addr` out AW: SRAM address.
- `mem_wdata` out DW: SRAM write data.
- `mem_gnt` in 1: SRAM accepts the request this cycle.
- `mem_rvalid` in 1: read data return, in order, any latency ≥1.
- `mem_rdata` in DW: read data.

## Operation

- **FSM states:** WAIT_VS → FLUSH → ACTIVE → DONE.
  - WAIT_VS: entered at reset. No fetch is issued; the host owns the port.
  - FLUSH: entered on a detected `vga_vsync` falling edge (registered compare), from any state. The FIFO is emptied and `fetch_addr` is loaded with FB_BASE. Each read still in flight gets its drop counter loaded with `outstanding`, and those returns are discarded. Leave FLUSH when `drop_cnt` = 0.
  - ACTIVE: fetch reads are issued. Go to DONE after HVA*VVA reads have been accepted.
  - DONE: no more fetch; the host owns the port until the next vsync edge.
- **Fetch eligibility:** state is ACTIVE and `level + outstanding < DEPTH`.
- **Arbitration, each cycle:**
  - If fetch is eligible and (`level + outstanding < HIWM` or `!host_req`), present the fetch read.
  - Otherwise, if `host_req`, present the host write.
  - `host_gnt = mem_gnt & mem_req & mem_we`.
- **Counters:**
  - `outstanding` increments when a read is accepted and decrements on `mem_rvalid`.
  - `fetch_addr` increments on each accepted read; width AW, no wrap inside a frame.
- **FIFO:**
  - Push on `mem_rvalid` when `drop_cnt` = 0; otherwise decrement `drop_cnt`.
  - Pop when `vga_video_on` is high and the FIFO is not empty.
  - A pop on empty sets `underrun`, leaves `pix_data` = 0, and does not move the pointers.
  - Simultaneous push and pop leave `level` unchanged. Overflow cannot occur because of the credit rule.
- **`first_pixel` while FIFO empty:** sets `underrun`.
- **Reset mid-operation:** all state is cleared immediately. Reads in flight at reset are the memory side's responsibility; the SRAM controller is reset together with this block.

## Timing

- **Reset values:** `pix_data`=0, `underrun`=0, `host_gnt`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. State is WAIT_VS, all counters and pointers are 0.
- **Memory outputs:** `mem_*` request outputs are combinational from registered state and `host_req`. `mem_req` holds stable until `mem_gnt`; a switch between requesters happens only after a grant.
- **Pop-to-output latency:** `pix_data` updates one cycle after the pop cycle.
- **Vsync edge:** FLUSH is entered one cycle after the vsync edge is detected.
- **Throughput:** one SRAM transaction per cycle when `mem_gnt` is held high.

## Structure

- **Shared package / `vga.vh`:** FSM state encodings and the derived constant `FRAME_PIX = HVA*VVA`. Resolution macros come from `vga.vh`.
- **Sub-module:** `vga_pix_fifo`, a synchronous FIFO with `level` output and a flush input.

## Test plan

- **Reset state:** reset low for 5 cycles, then release → all outputs 0, `mem_req`=0 until the first vsync edge.
- **Startup and fill:** SRAM model returning `rdata = addr` with 2-cycle latency; first vsync → first `mem_addr`=FB_BASE. The FIFO reaches 16 entries before `vga_video_on`, and `pix_data` runs 0,1,2,… with `underrun`=0 for the full frame.
- **End of frame:** after 307200 accepted reads → state DONE, no further reads, and host writes are granted back-to-back.
- **Host contention:** `host_req` held throughout → host is granted only when `level + outstanding ≥ 12` or the state is WAIT_VS/DONE, and no underrun occurs.
- **Vsync mid-frame:** vsync with 3 reads in flight → 3 returns dropped, next push is the data for FB_BASE.
- **Stalled SRAM:** `mem_gnt` forced low for 40 cycles during video → `underrun` goes to 1 and stays 1, and `pix_data`=0 on each empty pop.
